// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shift/rotate resolving one shift-amount bit per cycle
module iter_shift_unit #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(SHAMT_W - 1);
  localparam logic [SHAMT_W:0] FULL = (SHAMT_W + 1)'(WIDTH);
  state_t state;
  logic [WIDTH-1:0] acc, stepped, sll_v, srl_v, sra_v, ror_v;
  logic [SHAMT_W-1:0] shamt, cnt;
  logic [1:0] op;
  logic [SHAMT_W:0] amt;
  // one logarithmic stage of weight 2^cnt; arithmetic shift kept in its own signal so it stays signed
  always_comb begin
    amt = (SHAMT_W + 1)'(1) << cnt;
    sll_v = acc << amt;
    srl_v = acc >> amt;
    sra_v = $signed(acc) >>> amt;
    ror_v = (acc >> amt) | (acc << (FULL - amt));
    stepped = !shamt[cnt] ? acc : op == 2'd0 ? sll_v : op == 2'd1 ? srl_v : op == 2'd2 ? sra_v : ror_v;
  end
  // control FSM and datapath state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      shamt <= '0;
      op <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= in_data;
          shamt <= in_shamt;
          op <= in_op;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          acc <= stepped;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_data = acc;
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: directed and random checks of iter_shift_unit at WIDTH 32 and 8
module tb_iter_shift_unit;
  logic clk = 0, rst;
  logic v32, rdy32, ov32, or32, busy32;
  logic [31:0] d32, od32;
  logic [4:0] s32;
  logic [1:0] o32;
  logic v8, rdy8, ov8, or8, busy8;
  logic [7:0] d8, od8;
  logic [2:0] s8;
  logic [1:0] o8;
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  iter_shift_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
    .in_data(d32), .in_shamt(s32), .in_op(o32), .out_valid(ov32), .out_ready(or32),
    .out_data(od32), .busy(busy32));
  iter_shift_unit #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .in_data(d8), .in_shamt(s8), .in_op(o8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .busy(busy8));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] b, input logic [1:0] o);
    logic signed [31:0] sa;
    sa = a;
    case (o)
      2'd0: return a << b;
      2'd1: return a >> b;
      2'd2: return sa >>> b;
      default: return b == 0 ? a : (a >> b) | (a << (6'd32 - b));
    endcase
  endfunction
  task automatic start32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    v32 = 1; d32 = d; s32 = s; o32 = o;
    @(posedge clk); #1;
    v32 = 0;
  endtask
  task automatic wait32(output int lat);
    lat = 0;
    while (!ov32 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic pop32;
    or32 = 1;
    @(posedge clk); #1;
    or32 = 0;
  endtask
  task automatic op32(input string tag, input logic [31:0] d, input logic [4:0] s, input logic [1:0] o, input logic [31:0] exp);
    int lat;
    check({tag, " ready"}, rdy32, 1);
    start32(d, s, o);
    wait32(lat);
    check({tag, " data"}, od32, exp);
    check({tag, " lat"}, 32'(lat), 5);
    pop32;
    check({tag, " ready after"}, rdy32, 1);
  endtask
  task automatic op8(input string tag, input logic [7:0] d, input logic [2:0] s, input logic [1:0] o, input logic [7:0] exp);
    int lat;
    v8 = 1; d8 = d; s8 = s; o8 = o;
    @(posedge clk); #1;
    v8 = 0;
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, " data"}, {24'b0, od8}, {24'b0, exp});
    check({tag, " lat"}, 32'(lat), 3);
    or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
  endtask
  initial begin
    logic [31:0] held, rd, rexp;
    logic [4:0] rs;
    logic [1:0] ro;
    int lat, n, prev, acc_cyc;
    bit ok, done;
    rst = 1; v32 = 0; or32 = 0; d32 = 0; s32 = 0; o32 = 0;
    v8 = 0; or8 = 0; d8 = 0; s8 = 0; o8 = 0;
    #1;
    check("rst in_ready", rdy32, 0);
    check("rst out_valid", ov32, 0);
    check("rst out_data", od32, 0);
    check("rst busy", busy32, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    #1;
    check("post rst in_ready", rdy32, 1);
    op32("srl", 32'h8000_0000, 4, 2'd1, 32'h0800_0000);
    op32("sra", 32'h8000_0000, 4, 2'd2, 32'hF800_0000);
    op32("sll31", 32'h0000_0001, 31, 2'd0, 32'h8000_0000);
    op32("ror4", 32'h0000_00F1, 4, 2'd3, 32'h1000_000F);
    op32("sll0", 32'h1234_5678, 0, 2'd0, 32'h1234_5678);
    op32("srl0", 32'h1234_5678, 0, 2'd1, 32'h1234_5678);
    op32("sra0", 32'h1234_5678, 0, 2'd2, 32'h1234_5678);
    op32("ror0", 32'h1234_5678, 0, 2'd3, 32'h1234_5678);
    op32("ror31", 32'h0000_0001, 31, 2'd3, 32'h0000_0002);
    start32(32'hA5A5_0000, 8, 2'd1);
    check("busy in BUSY", busy32, 1);
    check("in_ready in BUSY", rdy32, 0);
    wait32(lat);
    held = od32;
    check("bp data", held, 32'h00A5_A500);
    for (int i = 0; i < 10; i++) begin
      v32 = i == 5; d32 = 32'hDEAD_BEEF; s32 = 1; o32 = 0;
      @(posedge clk); #1;
      v32 = 0;
      check("bp valid", ov32, 1);
      check("bp stable", od32, held);
      check("bp in_ready", rdy32, 0);
    end
    pop32;
    check("bp after valid", ov32, 0);
    check("bp after ready", rdy32, 1);
    start32(32'hFFFF_0000, 8, 2'd2);
    @(posedge clk); #1;
    rst = 1;
    #1;
    check("mid rst in_ready", rdy32, 0);
    check("mid rst out_valid", ov32, 0);
    check("mid rst out_data", od32, 0);
    check("mid rst busy", busy32, 0);
    #2 rst = 0;
    #1;
    check("mid rst ready after", rdy32, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no stale", ov32, 0);
    end
    prev = -1;
    for (int i = 0; i < 100; i++) begin
      rd = $urandom; rs = 5'($urandom_range(0, 31)); ro = 2'($urandom_range(0, 3));
      rexp = model(rd, rs, ro);
      v32 = 1; d32 = rd; s32 = rs; o32 = ro;
      ok = 0; n = 0;
      while (!ok && n < 50) begin ok = rdy32; @(posedge clk); #1; n++; end
      if (!ok) check("stream accept timeout", 0, 1);
      acc_cyc = cyc;
      if (prev >= 0) check("stream gap", 32'(acc_cyc - prev >= 7), 1);
      prev = acc_cyc;
      done = 0; n = 0;
      while (!done && n < 200) begin
        or32 = 1'($urandom_range(0, 1));
        if (ov32 && or32) begin check("stream data", od32, rexp); done = 1; end
        @(posedge clk); #1;
        n++;
      end
      or32 = 0;
      if (!done) check("stream result timeout", 0, 1);
    end
    v32 = 0;
    op8("w8 sra", 8'h90, 3, 2'd2, 8'hF2);
    op8("w8 ror", 8'h81, 1, 2'd3, 8'hC0);
    op8("w8 sll", 8'h81, 7, 2'd0, 8'h80);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Parametrised multi-cycle shift/rotate unit for the execute stage, used where a full combinational barrel shifter is too costly in area. It accepts one operand, a shift amount and an operation (SLL, SRL, SRA, ROR) over a valid/ready handshake. It resolves the shift one shift-amount bit per cycle, as a logarithmic shifter unrolled in time, then holds the result until the consumer takes it. It generalises the single-cycle right shifter with width parametrisation, left shift, rotate, flow control and a fixed multi-cycle latency.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 2
- SHAMT_W, $clog2(WIDTH), derived localparam; shift-amount width and iteration count
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount, unsigned, 0..WIDTH-1
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- busy  out  1  high in BUSY or DONE
- One clock; reset is asynchronous and active-high.

## Operation
- States are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_data into acc, and latch in_shamt and in_op.
  - Clear cnt to 0 and go to BUSY.
- BUSY:
  - Each cycle, if shamt[cnt]=1, update acc by 2^cnt positions per op:
    - SLL: zero fill from the LSB.
    - SRL: zero fill from the MSB.
    - SRA: fill with acc[WIDTH-1]. The sign is taken from the current acc, which equals the original sign.
    - ROR: bits shifted out of the LSB re-enter at the MSB.
  - If shamt[cnt]=0, acc is unchanged.
  - cnt increments each cycle. When cnt==SHAMT_W-1, the step is applied and the state goes to DONE.
- DONE:
  - out_valid=1 and out_data=acc, held stable.
  - On out_ready, go to IDLE.
- in_ready=0 in BUSY and DONE. Inputs are ignored there and need not be held by the producer after acceptance.
- out_data equals acc in all states, but is meaningful only while out_valid=1.
- Arithmetic:
  - Shift amount is modulo WIDTH by construction; no out-of-range case exists.
  - shamt=0 still runs the full iteration and returns in_data unchanged for every op.
  - Result equals the single-cycle reference for each op: a<<b, a>>b, $signed(a)>>>b, and (a>>b)|(a<<(WIDTH-b)) with b=0 giving a.
- Simultaneous events:
  - in_valid is ignored in DONE even when out_ready=1. The next accept occurs only in IDLE.
  - out_ready outside DONE has no effect.
- Reset, asserted at any time including mid-BUSY or DONE:
  - State goes to IDLE immediately.
  - acc, shamt, op and cnt clear to 0.
  - in_ready=1 once reset deasserts.
  - The in-flight operation is discarded and produces no output.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - While rst is high, in_ready=0.
- Acceptance edge E0 → BUSY for exactly SHAMT_W cycles → out_valid=1 after edge E0+SHAMT_W.
- Latency is SHAMT_W cycles: 5 for WIDTH=32, 3 for WIDTH=8.
- Latency is data independent.
- With out_ready held high, out_valid is high for exactly one cycle. in_ready rises the following cycle.
- Maximum throughput is one operation per SHAMT_W+2 cycles.
- Backpressure: out_valid and out_data are held indefinitely until out_ready=1.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.

## Test plan
- SRL and SRA, WIDTH=32, in_data=0x8000_0000, shamt=4:
  - SRL → 0x0800_0000.
  - SRA → 0xF800_0000.
  - Each has out_valid exactly 5 cycles after accept.
- SLL of 0x0000_0001 by 31 → 0x8000_0000. ROR of 0x0000_00F1 by 4 → 0x1000_000F. shamt=0 with each op → 0x1234_5678 unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE:
  - out_data is stable and out_valid=1.
  - in_ready=0 throughout.
  - A pulsed in_valid is ignored.
  - Releasing out_ready gives one result, then in_ready=1 next cycle.
- Reset mid-BUSY, asserted at cycle 2 of SRA 0xFFFF_0000 by 8:
  - After reset: out_valid=0, out_data=0, in_ready=1.
  - No stale result appears in the following 10 cycles.
- Back-to-back stream of 100 random ops (data, shamt, op) with random out_ready:
  - Results match the reference model in order.
  - Throughput never exceeds 1/(SHAMT_W+2).
- WIDTH=8 instance:
  - SRA 0x90 by 3 → 0xF2 with latency 3.
  - ROR 0x81 by 1 → 0xC0.
